// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe delay line.
// The REG_PIPE_OCC_EN build option relies on occ_width() to size its occupancy count.
package reg_pipe_pkg;

    localparam int unsigned REG_PIPE_INIT_DEFAULT = 0;

    // Wide enough to hold every count from 0 to depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic bit depth_valid(input int depth);
        return depth >= 1;
    endfunction

    function automatic bit width_valid(input int width);
        return width >= 1;
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One stage of the reg_pipe delay line: WIDTH data bits and one valid bit.
// When gate_data is 1, the data register loads only when the incoming item is valid.
module reg_pipe_stage #(
    parameter int unsigned WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             asyncreset_n,
    input  logic             ce,
    input  logic             flush,
    input  logic             gate_data,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // A flush clears valid even during a stall; an item arriving during a flush is treated as a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ce) begin
            valid_d = in_valid & ~flush;
            if (!gate_data || (in_valid && !flush)) begin
                data_d = in_data;
            end
        end else if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge asyncreset_n) begin
        if (!asyncreset_n) begin
            valid_q <= 1'b0;
            data_q  <= INIT;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage stallable, flushable register delay line with per-stage valid tracking.
// Defining REG_PIPE_OCC_EN adds the OCC output, which counts the stages currently holding valid data.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 2,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(REG_PIPE_INIT_DEFAULT),
    parameter int unsigned GATE_DATA = 0
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESET_N,
    input  logic                          CE,
    input  logic                          FLUSH,
    input  logic                          I_VALID,
    input  logic [WIDTH-1:0]              I,
`ifdef REG_PIPE_OCC_EN
    output logic [occ_width(DEPTH)-1:0]   OCC,
`endif
    output logic                          O_VALID,
    output logic [WIDTH-1:0]              O
);

    if (!depth_valid(DEPTH)) begin : g_bad_depth
        $error("reg_pipe: DEPTH must be at least 1");
    end
    if (!width_valid(WIDTH)) begin : g_bad_width
        $error("reg_pipe: WIDTH must be at least 1");
    end

    // Element 0 is the input side; element k+1 is the output of stage k.
    logic             valid_chain [0:DEPTH];
    logic [WIDTH-1:0] data_chain  [0:DEPTH];

    assign valid_chain[0] = I_VALID;
    assign data_chain[0]  = I;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        reg_pipe_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk          (CLK),
            .asyncreset_n (ASYNCRESET_N),
            .ce           (CE),
            .flush        (FLUSH),
            .gate_data    (GATE_DATA != 0),
            .in_valid     (valid_chain[k]),
            .in_data      (data_chain[k]),
            .out_valid    (valid_chain[k+1]),
            .out_data     (data_chain[k+1])
        );
    end

    assign O_VALID = valid_chain[DEPTH];
    assign O       = data_chain[DEPTH];

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_d, occ_q;

    // Items enter at the head and leave at the tail, so the count tracks the popcount of all valid bits.
    always_comb begin
        occ_d = occ_q;
        if (FLUSH) begin
            occ_d = '0;
        end else if (CE) begin
            occ_d = occ_q + OCC_W'(I_VALID) - OCC_W'(valid_chain[DEPTH]);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESET_N) begin
        if (!ASYNCRESET_N) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;
`endif

endmodule
